// File: rtl/pcie_tlp_req_gen_pkg.sv
// pcie_tlp_req_gen_pkg: shared TLP header types, FMT/TYPE codes and default sizing constants.
// PCIE_10B_TAG_EN selects the 10-bit tag width.
package pcie_tlp_req_gen_pkg;
  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [2:0] FMT_4DW_DATA   = 3'b011;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;
  localparam int DEF_MPS             = 128;
  localparam int DEF_MRRS            = 512;
  localparam int DEF_MAX_OUTSTANDING = 32;
`ifdef PCIE_10B_TAG_EN
  localparam int TAG_W = 10;
`else
  localparam int TAG_W = 8;
`endif
  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;
  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic        t9;
    logic [2:0]  tc;
    logic        t8;
    logic        attr2;
    logic        ln;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [1:0]  at;
    logic [9:0]  length;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  last_be;
    logic [3:0]  first_be;
    logic [31:0] addr;
  } mem_req_hdr_3dw_t;
  // In the 4DW form the base addr field carries the upper address word.
  typedef struct packed {
    mem_req_hdr_3dw_t base;
    logic [31:0]      addr_lo;
  } mem_req_hdr_4dw_t;
  function automatic logic [2:0] req_fmt(input logic write, input logic is4);
    return write ? (is4 ? FMT_4DW_DATA : FMT_3DW_DATA) : (is4 ? FMT_4DW_NODATA : FMT_3DW_NODATA);
  endfunction
endpackage

// File: rtl/pcie_tlp_chunk_calc.sv
// pcie_tlp_chunk_calc: bytes to emit in the next TLP, clipped to the next lim-aligned boundary.
module pcie_tlp_chunk_calc (
  input  logic [11:0] addr_lo,
  input  logic [12:0] rem,
  input  logic [12:0] lim,
  output logic [12:0] chunk
);
  logic [12:0] space;
  assign space = lim - {1'b0, addr_lo & 12'(lim - 13'd1)};
  assign chunk = rem < space ? rem : space;
endmodule

// File: rtl/pcie_tlp_req_gen.sv
// pcie_tlp_req_gen: splits DMA memory requests into PCIe MWr/MRd TLP headers with tag and read-credit tracking.
// Define PCIE_10B_TAG_EN for 10-bit tags (T9/T8 header bits).
module pcie_tlp_req_gen
  import pcie_tlp_req_gen_pkg::*;
#(
  parameter int ADDR_WIDTH       = 64,
  parameter int MAX_PAYLOAD_SIZE = DEF_MPS,
  parameter int MAX_READ_REQ     = DEF_MRRS,
  parameter int MAX_OUTSTANDING  = DEF_MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [12:0]           req_len,
  input  logic [15:0]           requester_id,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [127:0]          hdr,
  output logic                  hdr_4dw,
  output logic [10:0]           hdr_len_dw,
  output logic                  hdr_last,
  input  logic                  cpl_done,
  output logic                  busy
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [12:0]           rem_q, rem_d;
  logic                  write_q, write_d;
  logic [15:0]           id_q, id_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [OW-1:0]         outs_q, outs_d;
  logic [127:0]          hdr_q, hdr_d;
  logic                  hdr_4dw_q, hdr_4dw_d;
  logic [10:0]           len_dw_q, len_dw_d;
  logic                  last_q, last_d;
  logic [63:0]           addr64;
  logic [12:0]           lim, chunk;
  logic                  is4, hs, rd_hs, cpl;
  mem_req_hdr_3dw_t      h3;
  mem_req_hdr_4dw_t      h4;
  assign addr64 = 64'(addr_q);
  pcie_tlp_chunk_calc u_chunk (
    .addr_lo(addr_q[11:0]),
    .rem    (rem_q),
    .lim    (lim),
    .chunk  (chunk)
  );
  always_comb begin
    lim = write_q ? 13'(MAX_PAYLOAD_SIZE) : 13'(MAX_READ_REQ);
    is4 = addr64[63:32] != 32'h0;
    h3 = '0;
    h3.fmt = req_fmt(write_q, is4);
    h3.typ = TYPE_MEM;
    h3.length = chunk[11:2];
    h3.req_id = id_q;
    h3.tag = write_q ? 8'h00 : tag_q[7:0];
`ifdef PCIE_10B_TAG_EN
    h3.t9 = !write_q && tag_q[9];
    h3.t8 = !write_q && tag_q[8];
`endif
    h3.last_be = chunk > 13'd4 ? 4'hF : 4'h0;
    h3.first_be = 4'hF;
    h3.addr = is4 ? addr64[63:32] : addr64[31:0] & 32'hFFFF_FFFC;
    h4.base = h3;
    h4.addr_lo = addr64[31:0] & 32'hFFFF_FFFC;
    hs = state_q == EMIT && hdr_ready;
    rd_hs = hs && !write_q;
    cpl = cpl_done && outs_q != '0;
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    write_d = write_q;
    id_d = id_q;
    hdr_d = hdr_q;
    hdr_4dw_d = hdr_4dw_q;
    len_dw_d = len_dw_q;
    last_d = last_q;
    if (state_q == IDLE && req_valid) begin
      state_d = CALC;
      addr_d = req_addr;
      rem_d = req_len;
      write_d = req_write;
      id_d = requester_id;
    end
    // Reads park in CALC until a read credit frees up.
    if (state_q == CALC && (write_q || outs_q < MAX_OUT)) begin
      state_d = EMIT;
      hdr_d = is4 ? h4 : {h3, 32'h0};
      hdr_4dw_d = is4;
      len_dw_d = chunk[12:2];
      last_d = chunk == rem_q;
    end
    if (hs) begin
      state_d = last_q ? IDLE : CALC;
      addr_d = addr_q + ADDR_WIDTH'({len_dw_q, 2'b00});
      rem_d = rem_q - {len_dw_q, 2'b00};
    end
    tag_d = rd_hs ? tag_q + TAG_W'(1) : tag_q;
    outs_d = rd_hs && !cpl ? outs_q + OW'(1) : cpl && !rd_hs ? outs_q - OW'(1) : outs_q;
    req_ready = state_q == IDLE;
    hdr_valid = state_q == EMIT;
    busy = state_q != IDLE;
    hdr = hdr_q;
    hdr_4dw = hdr_4dw_q;
    hdr_len_dw = len_dw_q;
    hdr_last = last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      write_q <= 1'b0;
      id_q <= '0;
      tag_q <= '0;
      outs_q <= '0;
      hdr_q <= '0;
      hdr_4dw_q <= 1'b0;
      len_dw_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      write_q <= write_d;
      id_q <= id_d;
      tag_q <= tag_d;
      outs_q <= outs_d;
      hdr_q <= hdr_d;
      hdr_4dw_q <= hdr_4dw_d;
      len_dw_q <= len_dw_d;
      last_q <= last_d;
    end
  end
`ifndef SYNTHESIS
  a_req_legal: assert property (@(posedge clk) disable iff (!rst_n)
    req_valid && req_ready |-> req_addr[1:0] == 2'b00 && req_len >= 13'd4 && req_len <= 13'd4096 && req_len[1:0] == 2'b00);
  a_cpl_underflow: assert property (@(posedge clk) disable iff (!rst_n) cpl_done |-> outs_q != '0);
`endif
endmodule

// File: doc/pcie_tlp_req_gen.md
Name: pcie_tlp_req_gen

Overview:
- Converts DMA-style memory requests (64-bit address, byte length, read/write) into a stream of PCIe memory request TLP headers.
- Splits each request at MAX_PAYLOAD_SIZE (writes) or MAX_READ_REQ (reads) naturally-aligned boundaries.
- Selects 3DW or 4DW format per TLP, allocates read tags and throttles on outstanding reads.
- Sits between the DMA engine and the TX TLP mux. The payload path is handled downstream.

Parameters:
- ADDR_WIDTH, 64: request address width.
- MAX_PAYLOAD_SIZE, 128: write TLP byte limit; power of 2, 128..4096.
- MAX_READ_REQ, 512: read TLP byte limit; power of 2, 128..4096.
- MAX_OUTSTANDING, 32: maximum in-flight read TLPs, 1..256.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_write  in  1  1 = MWr, 0 = MRd.
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] must be 0.
- req_len  in  13  bytes; legal values are 4..4096 in multiples of 4.
- requester_id  in  16  BDF, sampled at request accept.
- hdr_valid  out  1  header valid.
- hdr_ready  in  1  downstream accept.
- hdr  out  128  header; byte 0 at [127:120]; DW3 = 0 when 3DW.
- hdr_4dw  out  1  header is 4DW.
- hdr_len_dw  out  11  chunk length in DW, 1..1024.
- hdr_last  out  1  last TLP of the current request.
- cpl_done  in  1  one read TLP fully completed; decrements the outstanding count.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset: req_ready=1, hdr_valid=0, hdr=0, hdr_4dw=0, hdr_len_dw=0, hdr_last=0, busy=0, tag counter=0, outstanding=0, FSM=IDLE. Reset mid-request discards the remainder of that request.
- FSM states:
  - IDLE: req_ready=1. On handshake, latch addr/len/write/id and go to CALC.
  - CALC (1 cycle): lim = write ? MPS : MRRS. chunk = min(rem, lim - (addr mod lim)). Build header. Go to EMIT.
  - EMIT: hdr_valid=1 and all header outputs held stable until hdr_ready.
    - On handshake: addr += chunk, rem -= chunk.
    - rem==0: go to IDLE, req_ready rises the same cycle as hdr_valid falls.
    - Otherwise go to CALC.
  - Reads additionally require outstanding < MAX_OUTSTANDING to enter EMIT; otherwise wait in CALC.
- Latency: first hdr_valid two cycles after request accept. Back-to-back TLPs of one request have a one-cycle gap.
- Header fields:
  - fmt: write 3'b010 (3DW) / 3'b011 (4DW); read 3'b000 / 3'b001.
  - type 5'b00000. TC, attr, LN, TH, TD, EP, AT all 0.
  - length = chunk/4, with 1024 DW encoded as 10'd0.
  - first_dw_be = 4'hF. last_dw_be = 4'hF if length>1, else 4'h0.
  - tag = tag counter for reads, 0 for writes.
  - 4DW when addr[63:32] != 0: DW2 = addr[63:32], DW3 = {addr[31:2], 2'b00}.
  - 3DW otherwise: DW2 = {addr[31:2], 2'b00}, DW3 = 0. PH = 0.
- 4 KB crossing cannot occur, because lim divides 4096 and chunks are lim-aligned.
- Tag counter: increments on each read header handshake and wraps modulo 2^8 (2^10 with the optional feature).
- Outstanding counter:
  - +1 on read header handshake; -1 on cpl_done.
  - Both in the same cycle: unchanged.
  - cpl_done at 0: ignored (simulation assertion fires).
- Illegal req_len or req_addr[1:0]≠0: behaviour undefined (simulation assertion fires).

Optional Feature:
- Macro PCIE_10B_TAG_EN.
- When defined: tag counter is 10 bits. Header bit T9 (byte 1 bit 7) = tag[9], T8 (byte 1 bit 3) = tag[8], tag byte = tag[7:0]. Counter wraps at 1024.
- When undefined: 8-bit counter, T9=T8=0, wraps at 256.

Decomposition:
- PCIE_PKG additions:
  - 4DW header typedef extending the existing 3DW memory request header with a 32-bit upper address.
  - FMT/TYPE localparams: FMT_3DW_NODATA, FMT_4DW_NODATA, FMT_3DW_DATA, FMT_4DW_DATA, TYPE_MEM.
  - Default MPS/MRRS constants.
- One sub-module: pcie_tlp_chunk_calc (combinational chunk size from addr, rem, lim), instantiated in CALC.

Test Plan:
1. MWr, addr 0x1000, len 256, MPS 128 → two 3DW headers with fmt 010, length 32, addresses 0x1000 then 0x1080; hdr_last only on the second.
2. MWr, addr 0x1040, len 128 → length 16 at 0x1040, then length 16 at 0x1080.
3. MRd, addr 0x1_0000_0000, len 1024, MRRS 512 → two 4DW headers with fmt 001, length 128, tags 0 and 1, DW2=0x1, DW3=0x0 then 0x200.
4. MAX_OUTSTANDING=2, MRd len 1536 with cpl_done held low → third header stalls. A cpl_done pulse releases it within 2 cycles. Simultaneous cpl_done and read handshake leaves the count unchanged.
5. MWr len 4 → length 1, first_be F, last_be 0. MRd len 4096 with MRRS 4096 → length field 0, hdr_len_dw 1024.
6. hdr_ready low for 10 cycles → hdr stable throughout. rst_n asserted in EMIT → outputs return to reset values asynchronously, and the next request starts cleanly at tag 0.
